data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: requester 0 is the core load/store path, requester 1 is the host/loader path.
- After reset, and on command, it zero-fills the whole memory with a clear sequence.
- In normal operation it grants at most one access per cycle using round-robin, and returns registered read data with a valid strobe.
- It sits between the requesters and the memory; the memory's own reset input is tied inactive.

Parameters:
W, 8, data width of each memory entry
A, 8, address width; memory depth is 2**A

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
clear_start  input  1  one-cycle pulse; restarts the zero-fill sequence
clear_done  output  1  1 when the memory is cleared and in RUN
req_valid  input  [1:0]  per-requester request valid
req_write  input  [1:0]  per-requester 1 = store, 0 = load
req_addr  input  [1:0][A-1:0]  per-requester address
req_wdata  input  [1:0][W-1:0]  per-requester store data
req_ready  output  [1:0]  grant; combinational, one-hot or zero
rsp_valid  output  [1:0]  one-cycle pulse; load data valid
rsp_rdata  output  [1:0][W-1:0]  load data; held until the next load response
mem_addr  output  A  to memory addr
mem_wdata  output  W  to memory data_to_write
mem_read_enabled  output  1  to memory read_enabled
mem_write_enabled  output  1  to memory write_enabled
mem_data_out  input  W  from memory; combinational read data

Behaviour:
- Reset (reset==0 at posedge): state=CLEAR, clr_cnt=0, rr_last=1 (requester 0 wins the first tie), clear_done=0, rsp_valid=0, rsp_rdata=0.
- Outputs while reset is held:
  - req_ready=0.
  - mem_*_enabled=0.
- CLEAR state:
  - mem_write_enabled=1, mem_addr=clr_cnt, mem_wdata=0, mem_read_enabled=0.
  - req_ready=2'b00.
  - clr_cnt increments every cycle.
  - When clr_cnt == 2**A-1, the write still happens that cycle; the next state is RUN and clr_cnt wraps to 0.
  - Fill takes exactly 2**A cycles. clear_done=1 starting the first RUN cycle.
- RUN state, arbitration (combinational):
  - If only one req_valid bit is set, grant it.
  - If both are set, grant the requester != rr_last.
  - rr_last updates to the granted index only on a grant.
  - req_ready[g]=1 only for the granted index g. A transaction is accepted when req_valid[g]&&req_ready[g].
- Memory drive on a grant:
  - mem_addr=req_addr[g].
  - Store: mem_write_enabled=1, mem_wdata=req_wdata[g], mem_read_enabled=0.
  - Load: mem_read_enabled=1, mem_write_enabled=0.
  - No grant: both enables 0, mem_addr=0, mem_wdata=0.
- Load latency:
  - mem_data_out is captured into rsp_rdata[g] at the accepting edge.
  - rsp_valid[g]=1 for exactly the next cycle.
  - A store produces no response. A store completes at the accepting edge.
- Back-to-back:
  - One access per cycle.
  - A requester holding valid with the other idle is granted every cycle.
  - With both valid, grants alternate 0,1,0,1.
- Boundary conditions:
  - clear_start in RUN: the next state is CLEAR, clr_cnt=0, clear_done falls the next cycle. No grant is issued in the cycle clear_start is high (req_ready=0).
  - clear_start in CLEAR: restarts the counter at 0.
  - Reset mid-CLEAR or mid-RUN returns to the reset values. A pending rsp_valid is dropped.
  - Address wrap: req_addr is A bits, so there is no out-of-range access.
  - Requesters must hold valid/addr/write/wdata stable until ready. The block does not buffer requests.

Decomposition:
- Package data_mem_pkg:
  - typedef enum {CLEAR, RUN} arb_state_t.
  - Constants REQ_CORE=0 and REQ_HOST=1.
  - NUM_REQ=2.
- Sub-module rr_arbiter2: two requests in, rr_last in, one-hot grant out, purely combinational.
- The FSM, counter and response registers stay in the top module.

Test Plan:
- Release reset with A=8 -> mem_write_enabled=1 for exactly 256 cycles, addr 0..255, wdata 0. clear_done rises on cycle 256. req_ready stays 0 throughout.
- In RUN, req 0 stores 0xA5 @0x10, then loads @0x10 -> store accepted in 1 cycle. The load gives rsp_valid[0]=1 one cycle after accept, rsp_rdata[0]=0xA5.
- Both requesters load continuously (addr 0x01 / 0x02) for 6 cycles -> grants 0,1,0,1,0,1. rsp_valid alternates with a 1-cycle lag, each with the correct data.
- Only req 1 valid for 4 cycles -> req_ready=2'b10 every cycle, 4 back-to-back accepts.
- clear_start pulsed while both are valid -> no grant that cycle. clear_done=0 next cycle. A load of the earlier address after the new clear_done returns 0x00.
- reset asserted at CLEAR cycle 100 -> the sequence restarts from addr 0. clear_done rises 256 cycles after release.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    localparam int NUM_REQ  = 2;
    localparam int REQ_CORE = 0;
    localparam int REQ_HOST = 1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: request handshake plus load response.
interface data_mem_arbiter_if
    import data_mem_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 8
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_write;
    logic [NUM_REQ-1:0][A-1:0]   req_addr;
    logic [NUM_REQ-1:0][W-1:0]   req_wdata;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [NUM_REQ-1:0][W-1:0]   rsp_rdata;

    // Requesters drive the request fields and observe grant and response.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // The arbiter observes requests and drives grant and response.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, purely combinational.
// rr_last is the index of the most recent winner; on a tie the other one wins.
module rr_arbiter2
    import data_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr_last,
    output logic [NUM_REQ-1:0] grant
);

    // Single requester wins outright; a tie goes to whoever did not win last.
    always_comb begin
        grant = '0;
        if (req[REQ_CORE] && req[REQ_HOST]) begin
            if (rr_last) begin
                grant[REQ_CORE] = 1'b1;
            end else begin
                grant[REQ_HOST] = 1'b1;
            end
        end else if (req[REQ_CORE]) begin
            grant[REQ_CORE] = 1'b1;
        end else if (req[REQ_HOST]) begin
            grant[REQ_HOST] = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between the core and host requesters.
// After reset or clear_start the whole memory is zero-filled, one entry per
// cycle; afterwards one access per cycle is granted round-robin and load data
// comes back registered one cycle after the accepting edge.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 8
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_start,
    output logic                 clear_done,
    data_mem_arbiter_if.slave    bus,
    output logic [A-1:0]         mem_addr,
    output logic [W-1:0]         mem_wdata,
    output logic                 mem_read_enabled,
    output logic                 mem_write_enabled,
    input  logic [W-1:0]         mem_data_out
);

    localparam logic [A-1:0] CLR_LAST = '1;

    arb_state_t          state_reg;
    arb_state_t          state_next;
    logic [A-1:0]        clr_cnt_reg;
    logic [A-1:0]        clr_cnt_next;
    logic                rr_last_reg;
    logic                clear_done_reg;

    logic                run_ok;
    logic [NUM_REQ-1:0]  req_eff;
    logic [NUM_REQ-1:0]  grant;
    logic                gidx;

    // Grants are only possible in RUN, out of reset, and not while a clear is requested.
    assign run_ok  = reset && (state_reg == RUN) && !clear_start;
    assign req_eff = bus.req_valid & {NUM_REQ{run_ok}};
    assign gidx    = grant[REQ_HOST];

    rr_arbiter2 u_rr_arbiter2 (
        .req     (req_eff),
        .rr_last (rr_last_reg),
        .grant   (grant)
    );

    assign bus.req_ready = grant;
    assign clear_done    = clear_done_reg;

    // State, fill counter, round-robin pointer and clear_done registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= CLEAR;
            clr_cnt_reg    <= '0;
            rr_last_reg    <= 1'b1;
            clear_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clr_cnt_reg    <= clr_cnt_next;
            clear_done_reg <= (state_next == RUN);
            if (|grant) begin
                rr_last_reg <= gidx;
            end
        end
    end

    // Next-state logic and memory drive for the fill sequence and granted accesses.
    always_comb begin
        state_next        = state_reg;
        clr_cnt_next      = clr_cnt_reg;
        mem_addr          = '0;
        mem_wdata         = '0;
        mem_read_enabled  = 1'b0;
        mem_write_enabled = 1'b0;
        case (state_reg)
            CLEAR: begin
                // The memory has no reset of its own, so hold it idle while ours is asserted.
                if (reset) begin
                    mem_write_enabled = 1'b1;
                    mem_addr          = clr_cnt_reg;
                end
                if (clear_start) begin
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == CLR_LAST) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (clear_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end else if (|grant) begin
                    mem_addr = bus.req_addr[gidx];
                    if (bus.req_write[gidx]) begin
                        mem_write_enabled = 1'b1;
                        mem_wdata         = bus.req_wdata[gidx];
                    end else begin
                        mem_read_enabled = 1'b1;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Per-requester load response: capture combinational read data at the accepting edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            logic         rsp_valid_reg;
            logic [W-1:0] rsp_rdata_reg;
            logic         load_accept;

            assign load_accept = grant[gi] && !bus.req_write[gi];

            // One-cycle valid pulse; data held until this requester's next load.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rsp_valid_reg <= 1'b0;
                    rsp_rdata_reg <= '0;
                end else begin
                    rsp_valid_reg <= load_accept;
                    if (load_accept) begin
                        rsp_rdata_reg <= mem_data_out;
                    end
                end
            end

            assign bus.rsp_valid[gi] = rsp_valid_reg;
            assign bus.rsp_rdata[gi] = rsp_rdata_reg;
        end
    endgenerate

endmodule
